// File: rtl/ticket_counter_arb.sv
// ticket_counter_arb
// Round-robin arbiter in front of a shared wrap-around ticket counter.
// Each grant hands the current count (1..KMAX, never 0) to the winner as a
// ticket and then advances the counter. A winner must drop its request before
// the arbiter will consider anyone again, so a held request is served once.
module ticket_counter_arb #(
  parameter int           N    = 4,
  parameter int           W    = 4,
  parameter logic [W-1:0] KMAX = 4'b1111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] gnt,
  output logic [W-1:0] ticket,
  output logic         busy,
  output logic         prop
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [W-1:0] ONE_W = W'(1);
  localparam logic [N-1:0] ONE_N = N'(1);

  logic [1:0]    state;
  logic [W-1:0]  count;
  // ptr doubles as the winner index: it is written with the winner at grant
  // time and is what RELEASE watches for the drop of req.
  logic [PW-1:0] ptr;

  logic          found;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;

  // Explicit wrap KMAX -> 1; never depends on W-bit overflow, so 0 is never produced.
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    return (v == KMAX) ? ONE_W : v + ONE_W;
  endfunction

  // Round-robin scan: first set req bit starting just after the last winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Control FSM, registered grant/ticket/busy outputs and the shared counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= ONE_W;
      ptr    <= PW'(N - 1);
      gnt    <= '0;
      ticket <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!hold && found) begin
            gnt    <= ONE_N << pick;
            ticket <= count;
            ptr    <= pick;
            busy   <= 1'b1;
            state  <= S_GRANT;
          end else begin
            gnt <= '0;
          end
        end
        S_GRANT: begin
          // Ticket already handed out as the pre-increment value; advance now.
          count  <= wrap_inc(count);
          gnt    <= '0;
          ticket <= '0;
          busy   <= 1'b1;
          state  <= S_RELEASE;
        end
        S_RELEASE: begin
          // Hold off re-arbitration until the winner lets go of its request.
          if (!req[ptr]) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          gnt    <= '0;
          ticket <= '0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Safety: counter never 0, grant at most one-hot, a live grant never carries ticket 0.
  assign prop = (count != '0)
             && ((gnt & (gnt - ONE_N)) == '0)
             && ((gnt == '0) || (ticket != '0));

  prop_holds: assert property (@(posedge clk) disable iff (!rst_n) prop);

endmodule

// File: tb/tb_ticket_counter_arb.sv
// Self-checking bench for ticket_counter_arb: directed scenarios with
// constant expectations plus a randomized run against a transaction model.
module tb_ticket_counter_arb;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int KMAX = 15;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic         hold  = 1'b0;
  logic [N-1:0] gnt;
  logic [W-1:0] ticket;
  logic         busy;
  logic         prop;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (ticket sequence, last winner, service window).
  bit           m_serving;
  int           m_age;
  int           m_next;
  int           m_last;
  logic [N-1:0] m_gnt;
  int           m_ticket;
  bit           m_busy;

  ticket_counter_arb #(.N(N), .W(W), .KMAX(4'b1111)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .hold   (hold),
    .gnt    (gnt),
    .ticket (ticket),
    .busy   (busy),
    .prop   (prop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (((r >> c) & N'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // One clock: capture what the DUT samples, advance the model, settle 1ns.
  task automatic tick();
    logic [N-1:0] r;
    logic         h;
    logic         rn;
    int           w;
    r  = req;
    h  = hold;
    rn = rst_n;
    @(posedge clk);
    if (!rn) begin
      m_serving = 0; m_age = 0; m_next = 1; m_last = N - 1;
      m_gnt = '0; m_ticket = 0;
    end else if (!m_serving) begin
      m_gnt = '0;
      if (!h && r != '0) begin
        w         = rr_pick(r, m_last);
        m_gnt     = N'(1) << w;
        m_ticket  = m_next;
        m_last    = w;
        m_serving = 1;
        m_age     = 0;
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_gnt  = '0;
        m_next = (m_next == KMAX) ? 1 : m_next + 1;
      end else if (((r >> m_last) & N'(1)) == '0) begin
        m_serving = 0;
      end
    end
    m_busy = m_serving;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; hold = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; hold = 1'b0;
    tick(); tick();
    vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: got %b, required %b", gnt, 4'b0000); end
    vectors++; if (ticket !== '0) begin miscompares++; $display("FAIL reset_ticket: got %0d, required 0", ticket); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++; if (prop !== 1'b1) begin miscompares++; $display("FAIL reset_prop: got %b, required 1", prop); end
    rst_n = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || gnt !== '0) begin miscompares++; $display("FAIL reset_idle: got busy=%b gnt=%b, required 0/0000", busy, gnt); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b, required 0100", gnt); end
    vectors++; if (ticket !== 4'd1) begin miscompares++; $display("FAIL single_ticket: got %0d, required 1", ticket); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy1: got %b, required 1", busy); end
    req = '0;
    tick();
    vectors++; if (gnt !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_release: got gnt=%b busy=%b, required 0000/1", gnt, busy); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop: got %b, required 0", busy); end
    req = 4'b0100;
    tick();
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt2: got %b, required 0100", gnt); end
    vectors++; if (ticket !== 4'd2) begin miscompares++; $display("FAIL single_ticket2: got %0d, required 2", ticket); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_all_held();
    int c;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      c = 0;
      do begin
        tick(); c++;
        vectors++; if ($countones(gnt) > 1) begin miscompares++; $display("FAIL allheld_onehot: got %b, required at most one bit", gnt); end
      end while (gnt == '0 && c < 8);
      vectors++;
      if (gnt == '0) begin
        miscompares++; $display("FAIL allheld_timeout: got no grant in %0d cycles, required grant %0d", c, g);
        break;
      end
      if (gnt !== (N'(1) << (g % N))) begin miscompares++; $display("FAIL allheld_order: got %b, required %b", gnt, N'(1) << (g % N)); end
      vectors++; if (ticket !== W'(g + 1)) begin miscompares++; $display("FAIL allheld_ticket: got %0d, required %0d", ticket, g + 1); end
      req = req & ~(N'(1) << (g % N));
      tick(); tick();
      req = 4'b1111;
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_wrap();
    int c;
    do_reset();
    for (int g = 0; g < 16; g++) begin
      req = 4'b0001;
      c = 0;
      do begin
        tick(); c++;
        vectors++; if (prop !== 1'b1) begin miscompares++; $display("FAIL wrap_prop: got %b, required 1", prop); end
      end while (gnt == '0 && c < 8);
      vectors++;
      if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wrap_gnt: got %b, required 0001", gnt); end
      vectors++;
      if (ticket !== W'((g % KMAX) + 1)) begin miscompares++; $display("FAIL wrap_ticket: got %0d, required %0d", ticket, (g % KMAX) + 1); end
      req = '0;
      tick();
      vectors++; if (prop !== 1'b1) begin miscompares++; $display("FAIL wrap_prop_rel: got %b, required 1", prop); end
      tick();
    end
  endtask

  task automatic test_release_hold();
    int c;
    do_reset();
    req = 4'b0010;
    tick();
    vectors++; if (gnt !== 4'b0010 || ticket !== 4'd1) begin miscompares++; $display("FAIL relhold_first: got gnt=%b ticket=%0d, required 0010/1", gnt, ticket); end
    req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (gnt !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL relhold_wait: got gnt=%b busy=%b, required 0000/1", gnt, busy); end
    end
    req = 4'b1000;
    c = 0;
    do begin tick(); c++; end while (gnt == '0 && c < 8);
    vectors++; if (gnt !== 4'b1000 || ticket !== 4'd2) begin miscompares++; $display("FAIL relhold_req3: got gnt=%b ticket=%0d, required 1000/2", gnt, ticket); end
    req = 4'b0010;
    c = 0;
    do begin tick(); c++; end while (gnt == '0 && c < 8);
    vectors++; if (gnt !== 4'b0010 || ticket !== 4'd3) begin miscompares++; $display("FAIL relhold_regrant: got gnt=%b ticket=%0d, required 0010/3", gnt, ticket); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1;
    req  = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (gnt !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL hold_block: got gnt=%b busy=%b, required 0000/0", gnt, busy); end
    end
    hold = 1'b0;
    tick();
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL hold_release_gnt: got %b, required 0001", gnt); end
    vectors++; if (ticket !== 4'd1) begin miscompares++; $display("FAIL hold_count: got %0d, required 1", ticket); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_grant();
    int c;
    do_reset();
    for (int g = 0; g < 7; g++) begin
      req = 4'b0001;
      c = 0;
      do begin tick(); c++; end while (gnt == '0 && c < 8);
      if (g == 6) break;
      req = '0;
      tick(); tick();
    end
    vectors++; if (gnt !== 4'b0001 || ticket !== 4'd7) begin miscompares++; $display("FAIL midrst_pre: got gnt=%b ticket=%0d, required 0001/7", gnt, ticket); end
    rst_n = 1'b0;
    req   = '0;
    tick();
    vectors++; if (gnt !== '0 || busy !== 1'b0 || ticket !== '0) begin miscompares++; $display("FAIL midrst_clear: got gnt=%b busy=%b ticket=%0d, required 0000/0/0", gnt, busy, ticket); end
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    vectors++; if (gnt !== 4'b0001 || ticket !== 4'd1) begin miscompares++; $display("FAIL midrst_next: got gnt=%b ticket=%0d, required 0001/1", gnt, ticket); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    int dly [N];
    do_reset();
    for (int i = 0; i < N; i++) dly[i] = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (((req >> i) & N'(1)) != '0) begin
          if (dly[i] == 0) begin
            req = req & ~(N'(1) << i);
            dly[i] = -1;
          end else if (dly[i] > 0) begin
            dly[i]--;
          end else if ($urandom_range(0, 31) == 0) begin
            req = req & ~(N'(1) << i);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req = req | (N'(1) << i);
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      tick();
      vectors++; if (gnt !== m_gnt) begin miscompares++; $display("FAIL rand_gnt @%0d: got %b, required %b", cyc, gnt, m_gnt); end
      vectors++; if (busy !== m_busy) begin miscompares++; $display("FAIL rand_busy @%0d: got %b, required %b", cyc, busy, m_busy); end
      if (m_gnt != '0) begin
        vectors++; if (ticket !== W'(m_ticket)) begin miscompares++; $display("FAIL rand_ticket @%0d: got %0d, required %0d", cyc, ticket, m_ticket); end
      end
      vectors++; if (prop !== 1'b1) begin miscompares++; $display("FAIL rand_prop @%0d: got %b, required 1", cyc, prop); end
      for (int i = 0; i < N; i++)
        if (((gnt >> i) & N'(1)) != '0) dly[i] = int'($urandom_range(0, 3));
    end
    hold = 1'b0;
    req  = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_held();
    test_wrap();
    test_release_hold();
    test_hold();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
